// File: rtl/vram_write_arbiter.sv
// Single owner of the VRAM write port: CPU writes go through a small FIFO, clear commands
// first drain that FIFO, then hand the port to clear_engine until it reports done.
module vram_write_arbiter #(
   parameter int          FIFO_DEPTH    = 4,
   parameter int          ROWS          = 30,
   parameter logic [15:0] NO_WRITE_ADDR = 16'h8000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cpu_we,
   input  logic [14:0] cpu_addr,
   input  logic [7:0]  cpu_data,
   output logic        cpu_ready,
   input  logic        clr_req,
   input  logic        clr_line_mode,
   input  logic [4:0]  clr_line_indx,
   output logic        clr_ack,
   output logic        clr_err,
   output logic        clr_busy,
   output logic        ce_start,
   output logic        ce_line_mode,
   output logic [4:0]  ce_line_indx,
   input  logic        ce_done,
   input  logic [15:0] ce_waddr,
   input  logic [7:0]  ce_wdata,
   output logic [15:0] vram_waddr,
   output logic [7:0]  vram_wdata
);

   localparam int          PW     = $clog2(FIFO_DEPTH);
   localparam logic [PW:0] FULL_N = (PW + 1)'(FIFO_DEPTH);
   localparam logic [5:0]  ROWS_W = 6'(ROWS);

   typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_CLEAR} state_t;

   state_t        state_q, state_d;
   logic [22:0]   mem_q [FIFO_DEPTH];
   logic [PW-1:0] wptr_q, rptr_q;
   logic [PW:0]   count_q, count_d;
   logic          ack_q, ack_d, err_q, err_d, start_q, start_d;
   logic          mode_q, mode_d;
   logic [4:0]    indx_q, indx_d;
   logic [15:0]   waddr_q, waddr_d;
   logic [7:0]    wdata_q, wdata_d;
   logic          push, pop;
   logic [22:0]   head;

   assign cpu_ready    = (count_q != FULL_N) && (state_q != S_DRAIN);
   assign push         = cpu_we && cpu_ready;
   assign head         = mem_q[rptr_q];
   assign count_d      = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
   assign clr_ack      = ack_q;
   assign clr_err      = err_q;
   assign clr_busy     = (state_q == S_DRAIN) || (state_q == S_CLEAR);
   assign ce_start     = start_q;
   assign ce_line_mode = mode_q;
   assign ce_line_indx = indx_q;
   assign vram_waddr   = waddr_q;
   assign vram_wdata   = wdata_q;

   always_comb begin
      state_d = state_q;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      start_d = 1'b0;
      mode_d  = mode_q;
      indx_d  = indx_q;
      waddr_d = NO_WRITE_ADDR;
      wdata_d = wdata_q;
      pop     = 1'b0;
      if (state_q != S_CLEAR && count_q != '0) begin
         pop     = 1'b1;
         waddr_d = {1'b0, head[22:8]};
         wdata_d = head[7:0];
      end
      case (state_q)
         S_IDLE: begin
            // Requester still sees its own ack this cycle; don't consume the same request twice.
            if (clr_req && !ack_q) begin
               if (clr_line_mode && ({1'b0, clr_line_indx} >= ROWS_W)) begin
                  ack_d = 1'b1;
                  err_d = 1'b1;
               end else begin
                  mode_d  = clr_line_mode;
                  indx_d  = clr_line_indx;
                  state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (count_q == '0) begin
               start_d = 1'b1;
               ack_d   = 1'b1;
               state_d = S_CLEAR;
            end
         end
         S_CLEAR: begin
            waddr_d = ce_waddr;
            wdata_d = ce_wdata;
            if (ce_done) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         start_q <= 1'b0;
         mode_q  <= 1'b0;
         indx_q  <= '0;
         waddr_q <= NO_WRITE_ADDR;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         if (push) wptr_q <= wptr_q + 1'b1;
         if (pop)  rptr_q <= rptr_q + 1'b1;
         ack_q   <= ack_d;
         err_q   <= err_d;
         start_q <= start_d;
         mode_q  <= mode_d;
         indx_q  <= indx_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
      end
   end

   // Storage carries no reset so it can map onto distributed RAM.
   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= {cpu_addr, cpu_data};
   end

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Directed bench for vram_write_arbiter with a behavioural clear_engine and a VRAM write log.
module tb_vram_write_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cpu_we = 1'b0;
   logic [14:0] cpu_addr = '0;
   logic [7:0]  cpu_data = '0;
   logic        cpu_ready;
   logic        clr_req = 1'b0;
   logic        clr_line_mode = 1'b0;
   logic [4:0]  clr_line_indx = '0;
   logic        clr_ack, clr_err, clr_busy, ce_start, ce_line_mode;
   logic [4:0]  ce_line_indx;
   logic        ce_done;
   logic [15:0] ce_waddr;
   logic [7:0]  ce_wdata;
   logic [15:0] vram_waddr;
   logic [7:0]  vram_wdata;

   int checks = 0;
   int fails  = 0;

   vram_write_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_ready(cpu_ready),
      .clr_req(clr_req), .clr_line_mode(clr_line_mode), .clr_line_indx(clr_line_indx),
      .clr_ack(clr_ack), .clr_err(clr_err), .clr_busy(clr_busy),
      .ce_start(ce_start), .ce_line_mode(ce_line_mode), .ce_line_indx(ce_line_indx),
      .ce_done(ce_done), .ce_waddr(ce_waddr), .ce_wdata(ce_wdata),
      .vram_waddr(vram_waddr), .vram_wdata(vram_wdata)
   );

   always #5 clk = ~clk;

   // Clear engine: 80 cells per line, 2400 for full screen, one write per cycle after start.
   logic eng_act;
   int   eng_idx, eng_total, eng_base;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         eng_act <= 1'b0; eng_idx <= 0; eng_total <= 1; eng_base <= 0;
      end else if (ce_start) begin
         eng_act   <= 1'b1;
         eng_idx   <= 0;
         eng_total <= ce_line_mode ? 80 : 2400;
         eng_base  <= ce_line_mode ? int'(ce_line_indx) * 80 : 0;
      end else if (eng_act) begin
         if (eng_idx == eng_total - 1) eng_act <= 1'b0;
         eng_idx <= eng_idx + 1;
      end
   end
   assign ce_waddr = eng_act ? {1'b0, 15'(eng_base + eng_idx)} : 16'h8000;
   assign ce_wdata = 8'h20;
   assign ce_done  = eng_act && (eng_idx == eng_total - 1);

   logic [23:0] wq [$];
   int ack_cnt = 0, err_cnt = 0, start_cnt = 0;
   always @(negedge clk) begin
      if (rst_n) begin
         if (!vram_waddr[15]) wq.push_back({vram_waddr, vram_wdata});
         if (clr_ack)  ack_cnt++;
         if (clr_err)  err_cnt++;
         if (ce_start) start_cnt++;
      end
   end

   task automatic wait_ack(input string name, output logic st, output logic er);
      int n = 0;
      st = 1'b0; er = 1'b0;
      @(negedge clk);
      while (!clr_ack && n < 200) begin @(negedge clk); n++; end
      checks++;
      if (!clr_ack) begin fails++; $display("FAIL %s: clr_ack never seen, required 1", name); end
      st = ce_start; er = clr_err;
      @(posedge clk); #1 clr_req = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (clr_busy && n < 3000) begin @(negedge clk); n++; end
      checks++;
      if (clr_busy) begin fails++; $display("FAIL %s: clr_busy still 1 after timeout, required 0", name); end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({cpu_ready, clr_ack, clr_err, clr_busy, ce_start, ce_line_mode} !== 6'b100000) begin
         fails++; $display("FAIL reset_flags: got %b, required 100000",
                           {cpu_ready, clr_ack, clr_err, clr_busy, ce_start, ce_line_mode});
      end
      checks++;
      if (vram_waddr !== 16'h8000 || vram_wdata !== 8'h00 || ce_line_indx !== 5'd0) begin
         fails++; $display("FAIL reset_vram: got %h/%h/%0d, required 8000/00/0",
                           vram_waddr, vram_wdata, ce_line_indx);
      end
      $display("reset: waddr=%h wdata=%h ready=%b", vram_waddr, vram_wdata, cpu_ready);
      @(posedge clk); #1 rst_n = 1'b1;
   endtask

   task automatic test_single_write();
      cpu_addr = 15'h0123; cpu_data = 8'h41; cpu_we = 1'b1;
      @(posedge clk); #1 cpu_we = 1'b0;
      @(negedge clk);
      checks++;
      if (vram_waddr !== 16'h8000) begin
         fails++; $display("FAIL latency_early: waddr %h, required 8000", vram_waddr);
      end
      @(negedge clk);
      checks++;
      if (vram_waddr !== 16'h0123 || vram_wdata !== 8'h41) begin
         fails++; $display("FAIL latency_write: got %h/%h, required 0123/41", vram_waddr, vram_wdata);
      end
      @(negedge clk);
      checks++;
      if (vram_waddr !== 16'h8000 || vram_wdata !== 8'h41) begin
         fails++; $display("FAIL write_idle: got %h/%h, required 8000/41", vram_waddr, vram_wdata);
      end
      $display("single write: 0123/41 seen two cycles after request");
   endtask

   task automatic test_back_to_back();
      logic st, er;
      int base, bad;
      clr_line_mode = 1'b1; clr_line_indx = 5'd0; clr_req = 1'b1;
      wait_ack("b2b_ack", st, er);
      base = wq.size();
      for (int i = 0; i < 5; i++) begin
         cpu_addr = 15'h0100 + 15'(i); cpu_data = 8'hA0 + 8'(i); cpu_we = 1'b1;
         @(negedge clk);
         checks++;
         if (cpu_ready !== (i < 4)) begin
            fails++; $display("FAIL b2b_ready[%0d]: got %b, required %b", i, cpu_ready, (i < 4));
         end
         @(posedge clk); #1;
      end
      cpu_we = 1'b0;
      wait_idle("b2b_idle");
      repeat (4) @(negedge clk);
      checks++;
      if (wq.size() - base !== 80 + 4) begin
         fails++; $display("FAIL b2b_count: got %0d writes, required 84", wq.size() - base);
      end else begin
         bad = 0;
         for (int i = 0; i < 80; i++) if (wq[base + i] !== {16'(i), 8'h20}) bad++;
         for (int i = 0; i < 4; i++)
            if (wq[base + 80 + i] !== {16'h0100 + 16'(i), 8'hA0 + 8'(i)}) bad++;
         checks++;
         if (bad != 0) begin fails++; $display("FAIL b2b_order: %0d misplaced writes, required 0", bad); end
      end
      $display("back-to-back: %0d writes logged", wq.size() - base);
   endtask

   task automatic test_drain_full();
      logic st, er;
      int base, a0, s0, bad;
      base = wq.size(); a0 = ack_cnt; s0 = start_cnt;
      for (int i = 0; i < 3; i++) begin
         cpu_addr = 15'h7000 + 15'(i); cpu_data = 8'h50 + 8'(i); cpu_we = 1'b1;
         if (i == 2) begin clr_req = 1'b1; clr_line_mode = 1'b0; clr_line_indx = 5'd31; end
         @(posedge clk); #1;
      end
      cpu_we = 1'b0;
      @(negedge clk);
      checks++;
      if (clr_busy !== 1'b1 || cpu_ready !== 1'b0) begin
         fails++; $display("FAIL drain_flags: busy=%b ready=%b, required 1/0", clr_busy, cpu_ready);
      end
      wait_ack("full_ack", st, er);
      checks++;
      if (st !== 1'b1 || er !== 1'b0) begin
         fails++; $display("FAIL full_ack_start: start=%b err=%b, required 1/0", st, er);
      end
      wait_idle("full_idle");
      checks++;
      if (wq.size() - base !== 2403) begin
         fails++; $display("FAIL full_count: got %0d writes, required 2403", wq.size() - base);
      end else begin
         bad = 0;
         for (int i = 0; i < 3; i++) if (wq[base + i] !== {16'h7000 + 16'(i), 8'h50 + 8'(i)}) bad++;
         for (int i = 0; i < 2400; i++) if (wq[base + 3 + i] !== {16'(i), 8'h20}) bad++;
         checks++;
         if (bad != 0) begin fails++; $display("FAIL full_order: %0d misplaced writes, required 0", bad); end
      end
      checks++;
      if (ack_cnt - a0 !== 1 || start_cnt - s0 !== 1) begin
         fails++; $display("FAIL full_pulses: acks=%0d starts=%0d, required 1/1", ack_cnt - a0, start_cnt - s0);
      end
      $display("full clear: %0d writes logged", wq.size() - base);
   endtask

   task automatic test_reject(input logic [4:0] indx);
      logic st, er;
      int a0, s0, e0;
      a0 = ack_cnt; s0 = start_cnt; e0 = err_cnt;
      clr_line_mode = 1'b1; clr_line_indx = indx; clr_req = 1'b1;
      wait_ack("reject_ack", st, er);
      checks++;
      if (er !== 1'b1 || st !== 1'b0) begin
         fails++; $display("FAIL reject_err[%0d]: err=%b start=%b, required 1/0", indx, er, st);
      end
      repeat (4) @(negedge clk);
      checks++;
      if (ack_cnt - a0 !== 1 || err_cnt - e0 !== 1 || start_cnt - s0 !== 0 ||
          clr_busy !== 1'b0 || cpu_ready !== 1'b1) begin
         fails++; $display("FAIL reject_after[%0d]: acks=%0d errs=%0d starts=%0d busy=%b ready=%b, required 1/1/0/0/1",
                           indx, ack_cnt - a0, err_cnt - e0, start_cnt - s0, clr_busy, cpu_ready);
      end
      $display("reject line %0d: err=%b", indx, er);
   endtask

   task automatic test_line_clear();
      logic st, er;
      int base, a0, bad;
      base = wq.size(); a0 = ack_cnt;
      clr_line_mode = 1'b1; clr_line_indx = 5'd5; clr_req = 1'b1;
      wait_ack("line_ack", st, er);
      checks++;
      if (ce_line_indx !== 5'd5 || ce_line_mode !== 1'b1 || st !== 1'b1) begin
         fails++; $display("FAIL line_latch: indx=%0d mode=%b start=%b, required 5/1/1",
                           ce_line_indx, ce_line_mode, st);
      end
      wait_idle("line_idle");
      bad = 0;
      for (int i = base; i < wq.size(); i++) if (wq[i][23:8] / 80 != 5) bad++;
      checks++;
      if (wq.size() - base !== 80 || bad != 0 || ack_cnt - a0 !== 1) begin
         fails++; $display("FAIL line_rows: writes=%0d off_row=%0d acks=%0d, required 80/0/1",
                           wq.size() - base, bad, ack_cnt - a0);
      end
      $display("line clear 5: %0d writes", wq.size() - base);
   endtask

   task automatic test_reset_mid_clear();
      logic st, er;
      int base;
      clr_line_mode = 1'b0; clr_req = 1'b1;
      wait_ack("midrst_ack", st, er);
      for (int i = 0; i < 2; i++) begin
         cpu_addr = 15'h0200 + 15'(i); cpu_data = 8'h77; cpu_we = 1'b1;
         @(posedge clk); #1;
      end
      cpu_we = 1'b0;
      repeat (5) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (vram_waddr !== 16'h8000 || vram_wdata !== 8'h00 || clr_busy !== 1'b0 ||
          ce_start !== 1'b0 || clr_ack !== 1'b0 || cpu_ready !== 1'b1) begin
         fails++; $display("FAIL midrst_outputs: waddr=%h wdata=%h busy=%b start=%b ack=%b ready=%b, required 8000/00/0/0/0/1",
                           vram_waddr, vram_wdata, clr_busy, ce_start, clr_ack, cpu_ready);
      end
      @(posedge clk); #1 rst_n = 1'b1;
      base = wq.size();
      repeat (6) @(negedge clk);
      checks++;
      if (wq.size() !== base || clr_busy !== 1'b0) begin
         fails++; $display("FAIL midrst_empty: %0d writes after release busy=%b, required 0/0",
                           wq.size() - base, clr_busy);
      end
      $display("reset mid-clear: outputs at reset values");
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_back_to_back();
      test_drain_full();
      test_reject(5'd31);
      test_reject(5'd30);
      test_line_clear();
      test_reset_mid_clear();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
